de10_periph_bridge: RTL and testbench

- Sits directly upstream of the DE10 peripheral register block. Converts the CPU data-port request/ready transactions into that block's single-cycle word interface: word address, write strobe, write data, and combinational read data.
- Decodes the peripheral address region and flags out-of-region or misaligned accesses.
- Implements byte-enable writes as read-modify-write, because the peripheral registers accept only full 32-bit writes.

---
 rtl/de10_periph_bridge.sv | 168 ++++++++++++++++
 tb/tb_de10_periph_bridge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/de10_periph_bridge.sv
// rtl/de10_periph_bridge.sv - CPU data-port to DE10 peripheral word-interface bridge
//
// Converts CPU request/ready transactions into the peripheral block's
// single-cycle word interface. It decodes the peripheral region and faults
// accesses that fall outside it or are not word aligned. It also turns
// byte-enable stores into read-modify-write, because the peripheral only
// accepts full 32-bit writes.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   cpu_req/wr/addr/      CPU request: valid, store flag, byte address,
//   cpu_wdata/be            store data, byte enables
//   cpu_ready/rdata/err   one-cycle response strobe, load data, fault flag
//   periph_addr           word index into the peripheral region
//   periph_wr/wdata       peripheral write strobe and full-word data
//   periph_rdata          combinational read data for periph_addr
//
// Optional: define PERIPH_BRIDGE_ERR_LATCH_EN to add err_valid/err_addr/err_clr,
// which latch the byte address of the first unacknowledged fault.

module de10_periph_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          REGION_BITS = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] periph_addr,
  output logic        periph_wr,
  output logic [31:0] periph_wdata,
  input  logic [31:0] periph_rdata
`ifdef PERIPH_BRIDGE_ERR_LATCH_EN
  ,
  output logic        err_valid,
  output logic [31:0] err_addr,
  input  logic        err_clr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [REGION_BITS-1:0] idx_q;
  logic                   wr_q;
  logic                   err_q;
  logic [31:0]            wdata_q;
  logic [3:0]             be_q;
  logic [31:0]            data_q;

  logic        hit;
  logic        fault;
  logic        accept;
  logic [31:0] merged;

  assign hit    = (cpu_addr[31:REGION_BITS+2] == BASE_ADDR[31:REGION_BITS+2]);
  assign fault  = !hit || (cpu_addr[1:0] != 2'b00);
  assign accept = (state_q == S_IDLE) && cpu_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= cpu_addr[REGION_BITS+1:2];
        wr_q    <= cpu_wr;
        err_q   <= fault;
        wdata_q <= cpu_wdata;
        be_q    <= cpu_be;
      end
      if (state_q == S_RD) begin
        data_q <= periph_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (fault) begin
            state_d = S_RESP;
          end else if (!cpu_wr) begin
            state_d = S_RD;
          end else if (cpu_be == 4'hF) begin
            state_d = S_WR;
          end else if (cpu_be == 4'h0) begin
            // Nothing to write: acknowledge without touching the peripheral.
            state_d = S_RESP;
          end else begin
            // Partial store: fetch the current word first so it can be merged.
            state_d = S_RD;
          end
        end
      end
      S_RD:   state_d = wr_q ? S_WR : S_RESP;
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte merge for read-modify-write; with all enables set data_q drops out.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : data_q[8*i +: 8];
    end
  end

  always_comb begin
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    cpu_err      = 1'b0;
    periph_addr  = '0;
    periph_wr    = 1'b0;
    periph_wdata = '0;
    if (state_q != S_IDLE) begin
      periph_addr = {{(32-REGION_BITS){1'b0}}, idx_q};
    end
    if (state_q == S_WR) begin
      periph_wr    = 1'b1;
      periph_wdata = merged;
    end
    if (state_q == S_RESP) begin
      cpu_ready = 1'b1;
      cpu_err   = err_q;
      cpu_rdata = (!wr_q && !err_q) ? data_q : 32'h0;
    end
  end

`ifdef PERIPH_BRIDGE_ERR_LATCH_EN
  // Captured on the accept edge so err_valid is already high in RESP.
  // A coincident err_clr lets the new fault replace the old record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (accept && fault && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= cpu_addr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_de10_periph_bridge.sv
// tb/tb_de10_periph_bridge.sv - directed table-driven bench for de10_periph_bridge

module tb_de10_periph_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [31:0] periph_addr;
  logic        periph_wr;
  logic [31:0] periph_wdata;
  logic [31:0] periph_rdata;
`ifdef PERIPH_BRIDGE_ERR_LATCH_EN
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_clr;
`endif

  int errors = 0;
  int checks = 0;

  de10_periph_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_wr       (cpu_wr),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_be       (cpu_be),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata),
    .cpu_err      (cpu_err),
    .periph_addr  (periph_addr),
    .periph_wr    (periph_wr),
    .periph_wdata (periph_wdata),
    .periph_rdata (periph_rdata)
`ifdef PERIPH_BRIDGE_ERR_LATCH_EN
    ,
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_clr      (err_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] prdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          nwr;
    logic [31:0] pwdata;
    logic [31:0] paddr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " cpu_ready"},    {31'd0, cpu_ready}, 32'd0);
    chk({tag, " cpu_rdata"},    cpu_rdata,          32'd0);
    chk({tag, " cpu_err"},      {31'd0, cpu_err},   32'd0);
    chk({tag, " periph_addr"},  periph_addr,        32'd0);
    chk({tag, " periph_wr"},    {31'd0, periph_wr}, 32'd0);
    chk({tag, " periph_wdata"}, periph_wdata,       32'd0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int lat, nwr;
    logic got, er;
    logic [31:0] rd, pw, pa;
    string t;
    v = vecs[idx];
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = v.wr; cpu_addr = v.addr;
    cpu_wdata = v.wdata; cpu_be = v.be; periph_rdata = v.prdata;
    @(posedge clk);
    // Scramble request fields while busy; the bridge must use its latched copy.
    #1;
    cpu_addr = 32'h4000_0001; cpu_wdata = 32'h0; cpu_be = 4'h0; cpu_wr = ~v.wr;
    lat = 0; nwr = 0; got = 1'b0; er = 1'b0; rd = '0; pw = '0; pa = '0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (c == 1) pa = periph_addr;
      if (periph_wr) begin
        nwr++;
        pw = periph_wdata;
      end
      if (cpu_ready) begin
        got = 1'b1; lat = c; rd = cpu_rdata; er = cpu_err;
        cpu_req = 1'b0;
      end
    end
    if (!got) begin
      cpu_req = 1'b0;
      chk({t, " ready timeout"}, 32'd0, 32'd1);
    end
    chk({t, " latency"},     lat,            v.lat);
    chk({t, " cpu_rdata"},   rd,             v.rdata);
    chk({t, " cpu_err"},     {31'd0, er},    {31'd0, v.err});
    chk({t, " wr pulses"},   nwr,            v.nwr);
    if (v.nwr > 0) chk({t, " periph_wdata"}, pw, v.pwdata);
    chk({t, " periph_addr"}, pa,             v.paddr);
  endtask

  initial begin
    logic [6:0] pat;
    int nrdy;
    logic [31:0] pa4, rd1;
    logic seen_ready;

    rst = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_be = '0; periph_rdata = '0;
`ifdef PERIPH_BRIDGE_ERR_LATCH_EN
    err_clr = 1'b0;
`endif

    //               wr    addr           wdata          be      prdata        lat rdata         err  nwr pwdata         paddr
    vecs[0] = '{1'b0, 32'h8000_0004, 32'h0,         4'hF,   32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0, 0, 32'h0,         32'h1};
    vecs[1] = '{1'b1, 32'h8000_0000, 32'h0000_03FF, 4'hF,   32'h1234_5678, 2, 32'h0,         1'b0, 1, 32'h0000_03FF, 32'h0};
    vecs[2] = '{1'b1, 32'h8000_0008, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344, 3, 32'h0,        1'b0, 1, 32'h11BB_33DD, 32'h2};
    vecs[3] = '{1'b0, 32'h4000_0000, 32'h0,         4'hF,   32'h5555_AAAA, 1, 32'h0,         1'b1, 0, 32'h0,         32'h0};
    vecs[4] = '{1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 4'hF,   32'h0,         1, 32'h0,         1'b1, 0, 32'h0,         32'h0};
    vecs[5] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0,   32'h0,         1, 32'h0,         1'b0, 0, 32'h0,         32'h4};
    vecs[6] = '{1'b0, 32'h80FF_FFFC, 32'h0,         4'hF,   32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b0, 0, 32'h0,         32'h003F_FFFF};
    vecs[7] = '{1'b1, 32'h8000_000C, 32'hAABB_CCDD, 4'b1000, 32'h1122_3344, 3, 32'h0,        1'b0, 1, 32'hAA22_3344, 32'h3};
    vecs[8] = '{1'b0, 32'h8100_0000, 32'h0,         4'hF,   32'h7777_7777, 1, 32'h0,         1'b1, 0, 32'h0,         32'h0};

    repeat (2) @(negedge clk);
    chk_idle_outputs("in reset");
`ifdef PERIPH_BRIDGE_ERR_LATCH_EN
    chk("reset err_valid", {31'd0, err_valid}, 32'd0);
    chk("reset err_addr",  err_addr,           32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after reset");

    for (int i = 0; i < 9; i++) run_vec(i);

`ifdef PERIPH_BRIDGE_ERR_LATCH_EN
    chk("err_valid held", {31'd0, err_valid}, 32'd1);
    chk("err_addr first", err_addr,           32'h4000_0000);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_valid cleared", {31'd0, err_valid}, 32'd0);
`endif

    // Back-to-back loads with cpu_req held through RESP.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h8000_0004; cpu_be = 4'hF;
    periph_rdata = 32'hCAFE_0001;
    @(posedge clk);
    pat = '0; nrdy = 0; pa4 = '0; rd1 = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 4) pa4 = periph_addr;
      if (cpu_ready) begin
        pat[c-1] = 1'b1;
        nrdy++;
        if (nrdy == 1) rd1 = cpu_rdata;
        if (nrdy == 2) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("b2b ready pattern", {25'd0, pat}, 32'b0010010);
    chk("b2b ready count",   nrdy,         32'd2);
    chk("b2b second accept", pa4,          32'd1);
    chk("b2b rdata",         rd1,          32'hCAFE_0001);

    // Reset asserted in the WR cycle of a partial store.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h8000_0008;
    cpu_wdata = 32'hAABB_CCDD; cpu_be = 4'b0101; periph_rdata = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rmw reaches WR", {31'd0, periph_wr}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async periph_wr drop", {31'd0, periph_wr}, 32'd0);
    cpu_req = 1'b0;
    seen_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cpu_ready || periph_wr) seen_ready = 1'b1;
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cpu_ready || periph_wr) seen_ready = 1'b1;
    end
    chk("no response after abort", {31'd0, seen_ready}, 32'd0);
    chk_idle_outputs("post abort");
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
